// File: rtl/minc2_pkg.sv
// minc2_pkg: opcodes, core states and sizing helper shared by the minc2 files
package minc2_pkg;
  localparam logic [3:0] OP_NOP = 4'h0, OP_LD = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                         OP_AND = 4'h4, OP_OR = 4'h5, OP_XOR = 4'h6, OP_JMP = 4'h7,
                         OP_JZ = 4'h8, OP_JC = 4'h9, OP_OUT = 4'hA, OP_HALT = 4'hB;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OUT_WAIT, ST_HALT} state_t;
  function automatic int max(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/minc2_if.sv
// minc2_if: host-facing program load, start and OUT valid/ready bundle
interface minc2_if #(parameter int DATA_W = 8, parameter int ADDR_W = 8);
  localparam int INSTR_W = 4 + minc2_pkg::max(DATA_W, ADDR_W);
  logic prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic start;
  logic out_ready;
  logic out_valid;
  logic [DATA_W-1:0] out_data;
  modport master (output prog_we, prog_addr, prog_data, start, out_ready, input out_valid, out_data);
  modport slave (input prog_we, prog_addr, prog_data, start, out_ready, output out_valid, out_data);
endinterface

// File: rtl/minc2_alu.sv
// minc2_alu: accumulator ALU; wr_acc marks ops that update acc and Z
module minc2_alu import minc2_pkg::*; #(parameter int DATA_W = 8) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] imm,
  input  logic              c_in,
  output logic [DATA_W-1:0] res,
  output logic              c_out,
  output logic              z_out,
  output logic              wr_acc
);
  logic [DATA_W:0] sum;
  always_comb begin
    sum = {1'b0, acc} + {1'b0, imm};
    res = acc;
    c_out = c_in;
    case (op)
      OP_LD: res = imm;
      OP_ADD: {c_out, res} = sum;
      OP_SUB: begin
        res = acc - imm;
        c_out = acc < imm;
      end
      OP_AND: res = acc & imm;
      OP_OR: res = acc | imm;
      OP_XOR: res = acc ^ imm;
      default: ;
    endcase
  end
  assign wr_acc = op != OP_NOP && op <= OP_XOR;
  assign z_out = res == '0;
endmodule

// File: rtl/minc2.sv
// minc2: accumulator core with writable program store, flags, jumps, HALT
// and a valid/ready OUT port that stalls execution until accepted.
module minc2 import minc2_pkg::*; #(parameter int DATA_W = 8, parameter int ADDR_W = 8) (
  input  logic              CLK,
  input  logic              nRESET,
  minc2_if.slave            bus,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out,
  output logic              flag_z,
  output logic              flag_c,
  output logic              busy,
  output logic              halted
);
  localparam int OPND_W = max(DATA_W, ADDR_W);
  localparam int INSTR_W = 4 + OPND_W;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc, tgt;
  logic [DATA_W-1:0] acc, acc_n, out_data, out_data_n, imm, res;
  logic z, z_n, c, c_n, out_valid, out_valid_n, c_alu, z_alu, wr_acc, idle_like;
  logic [INSTR_W-1:0] mem [2**ADDR_W];
  logic [INSTR_W-1:0] instr;
  logic [3:0] op;
  assign instr = mem[pc];
  assign op = instr[INSTR_W-1 -: 4];
  assign imm = instr[DATA_W-1:0];
  assign tgt = instr[ADDR_W-1:0];
  assign pc_inc = pc + ADDR_W'(1);
  assign idle_like = state == ST_IDLE || state == ST_HALT;
  minc2_alu #(.DATA_W(DATA_W)) u_alu (
    .op(op), .acc(acc), .imm(imm), .c_in(c),
    .res(res), .c_out(c_alu), .z_out(z_alu), .wr_acc(wr_acc)
  );
  // program store is deliberately left out of reset
  always_ff @(posedge CLK)
    if (bus.prog_we && idle_like) mem[bus.prog_addr] <= bus.prog_data;
  always_comb begin
    state_n = state;
    pc_n = pc;
    acc_n = acc;
    z_n = z;
    c_n = c;
    out_valid_n = out_valid;
    out_data_n = out_data;
    case (state)
      ST_IDLE, ST_HALT: if (bus.start) begin
        state_n = ST_RUN;
        pc_n = '0;
        acc_n = '0;
        z_n = 1'b0;
        c_n = 1'b0;
      end
      ST_RUN: begin
        pc_n = pc_inc;
        if (wr_acc) begin
          acc_n = res;
          z_n = z_alu;
          c_n = c_alu;
        end
        case (op)
          OP_JMP: pc_n = tgt;
          OP_JZ: pc_n = z ? tgt : pc_inc;
          OP_JC: pc_n = c ? tgt : pc_inc;
          OP_OUT: begin
            out_valid_n = 1'b1;
            out_data_n = acc;
            state_n = ST_OUT_WAIT;
          end
          OP_HALT: begin
            pc_n = pc;
            state_n = ST_HALT;
          end
          default: ;
        endcase
      end
      ST_OUT_WAIT: if (bus.out_ready) begin
        out_valid_n = 1'b0;
        state_n = ST_RUN;
      end
      default: ;
    endcase
  end
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      state <= ST_IDLE;
      pc <= '0;
      acc <= '0;
      z <= 1'b0;
      c <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      acc <= acc_n;
      z <= z_n;
      c <= c_n;
      out_valid <= out_valid_n;
      out_data <= out_data_n;
    end
  assign bus.out_valid = out_valid;
  assign bus.out_data = out_data;
  assign pc_out = pc;
  assign acc_out = acc;
  assign flag_z = z;
  assign flag_c = c;
  assign busy = state == ST_RUN || state == ST_OUT_WAIT;
  assign halted = state == ST_HALT;
endmodule

// File: tb/tb_minc2.sv
// tb_minc2: directed and random programs checked against an ISA-level model
module tb_minc2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] pc_out;
  logic [7:0] acc_out;
  logic flag_z, flag_c, busy, halted;
  int n_chk = 0, n_fail = 0, n;
  bit chk_en = 0;
  int pg[16];
  always #5 clk = ~clk;
  minc2_if #(.DATA_W(8), .ADDR_W(4)) bus ();
  minc2 #(.DATA_W(8), .ADDR_W(4)) dut (
    .CLK(clk), .nRESET(rst_n), .bus(bus), .pc_out(pc_out), .acc_out(acc_out),
    .flag_z(flag_z), .flag_c(flag_c), .busy(busy), .halted(halted)
  );
  // model: 0 idle, 1 run, 2 waiting for sink, 3 halted; plain integer arithmetic
  int m_st = 0, m_pc = 0, m_acc = 0, m_od = 0;
  bit m_z = 0, m_c = 0, m_ov = 0;
  int m_mem[16];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_ov = 0; m_od = 0;
    end else begin
      int op, v, nxt, wa, wd;
      bit we;
      we = bus.prog_we && (m_st == 0 || m_st == 3);
      wa = bus.prog_addr; wd = bus.prog_data;
      op = m_mem[m_pc] >> 8; v = m_mem[m_pc] & 255; nxt = (m_pc + 1) % 16;
      if (m_st == 0 || m_st == 3) begin
        if (bus.start) begin m_st = 1; m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; end
      end else if (m_st == 2) begin
        if (bus.out_ready) begin m_ov = 0; m_st = 1; end
      end else begin
        m_pc = nxt;
        case (op)
          1: m_acc = v;
          2: begin m_c = (m_acc + v) > 255; m_acc = (m_acc + v) % 256; end
          3: begin m_c = m_acc < v; m_acc = (m_acc - v + 256) % 256; end
          4: m_acc = m_acc & v;
          5: m_acc = m_acc | v;
          6: m_acc = m_acc ^ v;
          7: m_pc = v % 16;
          8: if (m_z) m_pc = v % 16;
          9: if (m_c) m_pc = v % 16;
          10: begin m_od = m_acc; m_ov = 1; m_st = 2; end
          11: begin m_st = 3; m_pc = (m_pc + 15) % 16; end
          default: ;
        endcase
        if (op >= 1 && op <= 6) m_z = m_acc == 0;
      end
      if (we) m_mem[wa] = wd;
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("pc", pc_out, m_pc); chk("acc", acc_out, m_acc);
    chk("z", flag_z, m_z); chk("c", flag_c, m_c);
    chk("out_valid", bus.out_valid, m_ov); chk("out_data", bus.out_data, m_od);
    chk("busy", busy, m_st == 1 || m_st == 2); chk("halted", halted, m_st == 3);
  end
  task automatic load();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); bus.prog_we = 1; bus.prog_addr = 4'(i); bus.prog_data = 12'(pg[i]);
    end
    @(negedge clk); bus.prog_we = 0;
  endtask
  task automatic wait_halt(input int maxc, output int cyc);
    cyc = 0;
    while (!halted && cyc < maxc) begin @(negedge clk); cyc++; end
    chk("halt_reached", halted, 1);
  endtask
  task automatic start_pulse();
    @(negedge clk); bus.start = 1; @(negedge clk); bus.start = 0;
  endtask
  task automatic reset_async();
    #2 rst_n = 0; #1;
    chk("rst_pc", pc_out, 0); chk("rst_acc", acc_out, 0); chk("rst_z", flag_z, 0);
    chk("rst_c", flag_c, 0); chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0); chk("rst_halted", halted, 0);
    @(negedge clk); rst_n = 1;
  endtask
  initial begin
    bus.prog_we = 0; bus.prog_addr = 0; bus.prog_data = 0; bus.start = 0; bus.out_ready = 1;
    repeat (2) @(negedge clk);
    chk("init_pc", pc_out, 0); chk("init_busy", busy, 0); chk("init_halted", halted, 0);
    chk_en = 1;
    rst_n = 1;
    // ADD with carry out
    pg = '{default: 0}; pg[0] = 'h1F0; pg[1] = 'h220; pg[2] = 'hB00;
    load(); start_pulse(); wait_halt(20, n);
    chk("add_cycles", n, 3); chk("add_acc", acc_out, 'h10); chk("add_c", flag_c, 1);
    chk("add_z", flag_z, 0); chk("add_pc", pc_out, 2);
    // SUB to zero, JZ taken
    pg = '{default: 0}; pg[0] = 'h105; pg[1] = 'h305; pg[2] = 'h806; pg[3] = 'hB00;
    pg[6] = 'h133; pg[7] = 'hB00;
    load(); start_pulse(); wait_halt(20, n);
    chk("jz_cycles", n, 5); chk("jz_acc", acc_out, 'h33); chk("jz_pc", pc_out, 7);
    // SUB with borrow, JZ falls through
    pg[1] = 'h306;
    load(); start_pulse(); wait_halt(20, n);
    chk("sub_cycles", n, 4); chk("sub_acc", acc_out, 'hFF); chk("sub_c", flag_c, 1);
    chk("sub_z", flag_z, 0); chk("sub_pc", pc_out, 3);
    // OUT with five stalled cycles before the sink accepts
    pg = '{default: 0}; pg[0] = 'h15A; pg[1] = 'hA00; pg[2] = 'h100; pg[3] = 'hB00;
    load(); bus.out_ready = 0; start_pulse();
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      chk("bp_valid", bus.out_valid, 1); chk("bp_data", bus.out_data, 'h5A);
      chk("bp_pc", pc_out, 2); chk("bp_acc", acc_out, 'h5A);
    end
    bus.out_ready = 1;
    @(negedge clk);
    chk("acc_valid", bus.out_valid, 0); chk("acc_hold", acc_out, 'h5A); chk("acc_busy", busy, 1);
    @(negedge clk);
    chk("ld0_acc", acc_out, 0); chk("ld0_data", bus.out_data, 'h5A); chk("ld0_pc", pc_out, 3);
    wait_halt(10, n);
    // reset while an OUT is pending
    pg = '{default: 0}; pg[0] = 'h1C3; pg[1] = 'hA00; pg[2] = 'hB00;
    load(); bus.out_ready = 0; start_pulse();
    repeat (4) @(negedge clk);
    chk("pend_valid", bus.out_valid, 1);
    reset_async();
    bus.out_ready = 1;
    // NOP program: write during RUN is ignored, pc wraps
    pg = '{default: 0};
    load(); start_pulse();
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      bus.prog_we = j == 3; bus.prog_addr = 5; bus.prog_data = 'hB00;
      if (j == 15) chk("wrap_pc15", pc_out, 15);
      if (j == 16) chk("wrap_pc0", pc_out, 0);
    end
    chk("gate_halted", halted, 0);
    reset_async();
    start_pulse();
    repeat (20) @(negedge clk);
    chk("readback_halted", halted, 0); chk("readback_pc", pc_out, 4);
    reset_async();
    // restart from HALT with a same-cycle write to address 0
    pg = '{default: 0}; pg[0] = 'h1F0; pg[1] = 'h210; pg[2] = 'hB00;
    load(); start_pulse(); wait_halt(20, n);
    chk("pre_z", flag_z, 1); chk("pre_c", flag_c, 1); chk("pre_acc", acc_out, 0);
    @(negedge clk); bus.prog_we = 1; bus.prog_addr = 1; bus.prog_data = 'hB00;
    @(negedge clk); bus.prog_addr = 0; bus.prog_data = 'h177; bus.start = 1;
    @(negedge clk); bus.prog_we = 0; bus.start = 0;
    chk("rs_z", flag_z, 0); chk("rs_c", flag_c, 0); chk("rs_pc", pc_out, 0); chk("rs_busy", busy, 1);
    wait_halt(10, n);
    chk("rs_acc", acc_out, 'h77); chk("rs_hpc", pc_out, 1);
    // random programs with random sink, start and write attempts
    for (int r = 0; r < 8; r++) begin
      foreach (pg[i]) pg[i] = int'($urandom & 'hFFF);
      load();
      bus.start = 1;
      for (int t = 0; t < 300; t++) begin
        @(negedge clk);
        bus.start = $urandom_range(0, 19) == 0;
        bus.prog_we = $urandom_range(0, 7) == 0;
        bus.prog_addr = 4'($urandom);
        bus.prog_data = 12'($urandom);
        bus.out_ready = $urandom_range(0, 2) != 0;
      end
      bus.start = 0; bus.prog_we = 0; bus.out_ready = 1;
      reset_async();
    end
    @(negedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
